rv32_regfile_mp: RTL

Parametrised multi-port integer register file with an integrated register scoreboard. It serves the next-generation core's decode/issue stage (read ports plus busy flags) and writeback stage (write ports). Entry 0 is hardwired to zero. Per-register busy bits track outstanding producers so issue can stall on RAW/WAW hazards.

---
 rtl/rv32_regs_pkg.sv | 13 +
 rtl/rv32_regfile_mp_if.sv | 35 +++
 rtl/rv32_scoreboard.sv | 90 +++++++++
 rtl/rv32_regfile_mp.sv | 66 ++++++
 4 files changed

// File: rtl/rv32_regs_pkg.sv
// Shared defaults and types for the rv32 integer register file slice.
package rv32_regs_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rv32_regfile_mp_if.sv
// Read, write and issue signal bundle of the multi-port register file.
interface rv32_regfile_mp_if
  import rv32_regs_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) ();

  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic [NUM_WR-1:0]      wr_clr;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   issue_ready;
  logic                   wb_stray;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_clr, issue_valid, issue_rd,
    input  rd_data, rd_busy, issue_ready, wb_stray
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, issue_valid, issue_rd,
    output rd_data, rd_busy, issue_ready, wb_stray
  );

endinterface

// File: rtl/rv32_scoreboard.sv
// Per-register busy bits with issue set, writeback clear and stray-clear detection.
// RV32_REGFILE_BYPASS_EN makes a same-cycle writeback clear visible on rd_busy/issue_ready.
module rv32_scoreboard
  import rv32_regs_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_RD*$clog2(NREGS)-1:0]  rd_addr,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*$clog2(NREGS)-1:0]  wr_addr,
  input  logic [NUM_WR-1:0]                wr_clr,
  input  logic                             issue_valid,
  input  logic [$clog2(NREGS)-1:0]         issue_rd,
  output logic [NUM_RD-1:0]                rd_busy,
  output logic                             issue_ready,
  output logic                             wb_stray
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] clr_vec;
  logic             stray_now;
  logic             issue_acc;
`ifdef RV32_REGFILE_BYPASS_EN
  logic             fwd_clr;
`endif

  always_comb begin
    clr_vec   = '0;
    stray_now = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wr_clr[j] && wr_addr[j*AW +: AW] != '0) begin
        clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
        if (!busy[wr_addr[j*AW +: AW]])
          stray_now = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef RV32_REGFILE_BYPASS_EN
    issue_ready = (issue_rd == '0) || !busy[issue_rd] || clr_vec[issue_rd];
`else
    issue_ready = (issue_rd == '0) || !busy[issue_rd];
`endif
    issue_acc = issue_valid && issue_ready && (issue_rd != '0);
    // A new producer supersedes a retiring one, so the set is applied after the clear.
    busy_next = busy & ~clr_vec;
    if (issue_acc)
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    rd_busy = '0;
`ifdef RV32_REGFILE_BYPASS_EN
    fwd_clr = 1'b0;
`endif
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = busy[rd_addr[i*AW +: AW]];
`ifdef RV32_REGFILE_BYPASS_EN
      fwd_clr = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && rd_addr[i*AW +: AW] != '0 &&
            wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
          fwd_clr = wr_clr[j];
      end
      if (fwd_clr && !(issue_acc && issue_rd == rd_addr[i*AW +: AW]))
        rd_busy[i] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy     <= '0;
      wb_stray <= 1'b0;
    end else begin
      busy     <= busy_next;
      wb_stray <= stray_now;
    end
  end

endmodule

// File: rtl/rv32_regfile_mp.sv
// Multi-port integer register file (x0 hardwired to zero) with integrated busy scoreboard.
// RV32_REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module rv32_regfile_mp
  import rv32_regs_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  rv32_regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] mem [NREGS];

  // Ports are walked in ascending order so the highest-indexed writer wins a collision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
          mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_addr[i*AW +: AW] != '0)
        bus.rd_data[i*XLEN +: XLEN] = mem[bus.rd_addr[i*AW +: AW]];
`ifdef RV32_REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && bus.rd_addr[i*AW +: AW] != '0 &&
            bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])
          bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
      end
`endif
    end
  end

  rv32_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr     (bus.rd_addr),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .wr_clr      (bus.wr_clr),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .rd_busy     (bus.rd_busy),
    .issue_ready (bus.issue_ready),
    .wb_stray    (bus.wb_stray)
  );

endmodule
